// File: rtl/mdu_iter.sv
// Iterative MULT/DIV: WIDTH+1 cycles start-to-result_valid, stall held while busy, cancel aborts to IDLE.
// Define MDU_FAST_MULT_EN for a single-cycle array multiply (result_valid 2 cycles after start).
module mdu_iter #(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_mult,
  input  logic             is_div,
  input  logic             signed_op,
  input  logic             cancel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             stall,
  output logic             busy,
  output logic             result_valid,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mag_b_q, mag_b_d;
  logic [WIDTH-1:0]   a_raw_q, a_raw_d;
  logic               sa_q, sa_d, sb_q, sb_d;
  logic               busy_q, busy_d;
  logic               rv_q, rv_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;

  logic               accept;
  logic [2*WIDTH-1:0] mul_next, div_next, prod;
  logic [WIDTH:0]     mul_sum, rem_sh;
  logic [WIDTH+1:0]   rem_diff;
  logic [WIDTH-1:0]   quo, rem;

  assign accept = (state_q == S_IDLE || state_q == S_DONE) & start & (is_mult | is_div) & ~cancel;

  // acc holds {partial product, remaining multiplier} for MUL and {remainder, dividend/quotient} for DIV
  always_comb begin
`ifdef MDU_FAST_MULT_EN
    mul_sum  = '0;
    mul_next = {{WIDTH{1'b0}}, acc_q[WIDTH-1:0]} * {{WIDTH{1'b0}}, mag_b_q};
`else
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mag_b_q} : '0);
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};
`endif
    rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    rem_diff = {1'b0, rem_sh} - {2'b00, mag_b_q};
    if (!rem_diff[WIDTH+1]) div_next = {rem_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    else                    div_next = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    prod = (sa_q ^ sb_q) ? -mul_next : mul_next;
    quo  = (sa_q ^ sb_q) ? -div_next[WIDTH-1:0] : div_next[WIDTH-1:0];
    rem  = sa_q ? -div_next[2*WIDTH-1:WIDTH] : div_next[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mag_b_d = mag_b_q;
    a_raw_d = a_raw_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    rv_d    = 1'b0;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (accept) begin
          state_d = is_mult ? S_MUL : S_DIV;
`ifdef MDU_FAST_MULT_EN
          cnt_d   = is_mult ? '0 : CNT_W'(WIDTH - 1);
`else
          cnt_d   = CNT_W'(WIDTH - 1);
`endif
          sa_d    = signed_op & a[WIDTH-1];
          sb_d    = signed_op & b[WIDTH-1];
          a_raw_d = a;
          mag_b_d = sb_d ? -b : b;
          acc_d   = {{WIDTH{1'b0}}, (sa_d ? -a : a)};
        end
      end
      S_MUL, S_DIV: begin
        if (cancel) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          acc_d = (state_q == S_MUL) ? mul_next : div_next;
          if (cnt_q == '0) begin
            state_d = S_DONE;
            rv_d    = 1'b1;
            if (state_q == S_MUL) begin
              {hi_d, lo_d} = prod;
            end else if (mag_b_q == '0) begin
              // divide by zero returns the untouched dividend pattern in hi
              hi_d = a_raw_q;
              lo_d = '1;
            end else begin
              hi_d = rem;
              lo_d = quo;
            end
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_MUL) || (state_d == S_DIV);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      mag_b_q <= '0;
      a_raw_q <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      busy_q  <= 1'b0;
      rv_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mag_b_q <= mag_b_d;
      a_raw_q <= a_raw_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      busy_q  <= busy_d;
      rv_q    <= rv_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign stall        = accept | busy_q;
  assign busy         = busy_q;
  assign result_valid = rv_q;
  assign hi           = hi_q;
  assign lo           = lo_q;

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Parametrised iterative multiply/divide unit for the 5-stage MIPS core. Executes MULT/MULTU/DIV/DIVU on WIDTH-bit operands and produces HI/LO results.
- Sits beside the EX-stage ALU. It raises a stall request while an operation runs and returns to idle on a pipeline flush.
- Successor to the fixed 32-bit mult/div path:
  - adds a width parameter;
  - adds multi-cycle iteration with explicit stall;
  - adds a cancel input;
  - defines results for divide-by-zero.

Parameters:
- WIDTH, 32, operand width in bits (>=4, even). HI and LO are each WIDTH bits.
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, not overridden).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- start  in  1  request a new operation. Sampled only in IDLE or DONE.
- is_mult  in  1  operation is multiply
- is_div  in  1  operation is divide. is_mult has priority if both are set.
- signed_op  in  1  1 = two's-complement operands, 0 = unsigned
- cancel  in  1  flush: abort the current operation
- a  in  WIDTH  multiplicand / dividend
- b  in  WIDTH  multiplier / divisor
- stall  out  1  hold the pipeline (combinational)
- busy  out  1  registered; 1 in the MUL or DIV state
- result_valid  out  1  registered one-cycle pulse; HI/LO are updated this cycle
- hi  out  WIDTH  product[2W-1:W] or remainder
- lo  out  WIDTH  product[W-1:0] or quotient

Behaviour:
- Reset: state=IDLE, hi=0, lo=0, busy=0, result_valid=0, counter=0. Reset overrides all other inputs, including mid-operation; any partial result is discarded.
- States: IDLE, MUL, DIV, DONE.
  - IDLE/DONE with start & is_mult & !cancel -> MUL.
  - IDLE/DONE with start & is_div & !is_mult & !cancel -> DIV.
  - Any other case -> IDLE.
  - MUL/DIV: counter decrements from WIDTH-1. When it reaches 0 -> DONE.
  - MUL/DIV with cancel -> IDLE.
- Accept: operands a and b are latched on the start edge. If signed_op=1, their magnitudes are stored along with sign bits sa, sb. Later changes on a and b are ignored.
- Latency: start sampled at edge 0 -> WIDTH iteration cycles -> result_valid=1 during cycle WIDTH+1, with hi/lo already holding the new values.
- Back-to-back: start in DONE begins a new operation immediately, so there are no idle cycles between operations.
- Multiply: radix-2 shift-add, one partial product per cycle. Final 2W-bit product:
  - negated if signed_op & (sa^sb);
  - {hi,lo} = product.
- Divide: restoring, one quotient bit per cycle on the magnitudes. Then:
  - quotient negated if sa^sb;
  - remainder takes the sign of the dividend (sa);
  - lo = quotient, hi = remainder.
- Divide by zero (b=0), signed or unsigned: lo = all ones, hi = original a (unmodified bit pattern). Latency is unchanged.
- Signed overflow MIN/-1: lo = MIN, hi = 0.
- stall = (start & is_mult|is_div & state in {IDLE,DONE} & !cancel) | busy. Stall is low in DONE so the pipeline advances with the result present.
- Cancel:
  - takes priority over start in the same cycle;
  - next state is IDLE;
  - result_valid is never asserted for the cancelled operation;
  - hi/lo keep their previous values.
- start with neither is_mult nor is_div: ignored, state stays IDLE.
- start while busy: ignored.
- hi and lo change only on entry to DONE (or reset).

Optional Feature:
- MDU_FAST_MULT_EN:
  - Defined: multiply is a single-cycle array multiply. MUL runs exactly one cycle, so result_valid is asserted in cycle 2 after start. Divide is unchanged.
  - Undefined: iterative WIDTH-cycle multiply as described above.
  - Port list is identical in both builds.

Test Plan:
- WIDTH=32, unsigned mult a=0xFFFFFFFF, b=2 -> stall high cycles 0..32; result_valid in cycle 33; hi=0x00000001, lo=0xFFFFFFFE.
- Signed div a=-7 (0xFFFFFFF9), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); same latency as mult.
- Unsigned and signed div a=0x12345678, b=0 -> lo=0xFFFFFFFF, hi=0x12345678, result_valid in cycle 33. Signed a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Start signed mult 3*-4, assert cancel in cycle 10 -> IDLE in cycle 11, busy=0, no result_valid, hi/lo keep the prior result. Then start 3*-4 again -> hi=0xFFFFFFFF, lo=0xFFFFFFF4.
- rst asserted in cycle 15 of a divide -> next cycle busy=0, stall=0, hi=lo=0. Start with start=1 but is_mult=is_div=0 -> stays IDLE.
- WIDTH=8 with MDU_FAST_MULT_EN defined: signed 0x80*0x80 -> result_valid in cycle 2, hi=0x40, lo=0x00. Back-to-back start in DONE accepted with no gap.
